issue_scoreboard: RTL and testbench

- Parametrised successor to the fixed two-source, single-load-slot RAW checks in the top-level pipeline.
- Tracks up to MAX_PEND in-flight writers per architectural register, using an in-order sequence tag.
- Sits between decode and execute. Issues a single issue_ready (stall) plus per-source pending/tag outputs that the datapath uses to select forwarding.
- Supports NUM_SRC source operands and load-use stalls that release on load-data return.

---
 rtl/issue_scoreboard.sv | 121 ++++++++++++
 tb/tb_issue_scoreboard.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// Per-register RAW/load-use scoreboard between decode and execute, with in-order sequence tags.
// Optional macro SCOREBOARD_WAW_STALL_EN: allow at most one in-flight writer per register.
module issue_scoreboard #(
    parameter int NUM_REGS  = 32,
    parameter int REG_IDX_W = 5,
    parameter int NUM_SRC   = 2,
    parameter int MAX_PEND  = 3,
    parameter int CNT_W     = 2,
    parameter int SEQ_W     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         issue_valid,
    output logic                         issue_ready,
    input  logic                         issue_wen,
    input  logic [REG_IDX_W-1:0]         issue_dst,
    input  logic                         issue_is_load,
    input  logic [NUM_SRC*REG_IDX_W-1:0] issue_src,
    input  logic [NUM_SRC-1:0]           issue_src_en,
    output logic [SEQ_W-1:0]             issue_tag,
    output logic [NUM_SRC-1:0]           src_pend,
    output logic [NUM_SRC*SEQ_W-1:0]     src_tag,
    input  logic                         ld_ret_valid,
    input  logic [REG_IDX_W-1:0]         ld_ret_dst,
    input  logic [SEQ_W-1:0]             ld_ret_tag,
    input  logic                         retire_valid,
    input  logic [REG_IDX_W-1:0]         retire_dst
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PEND);

    logic [CNT_W-1:0]     cnt_q  [NUM_REGS];
    logic [CNT_W-1:0]     cnt_d  [NUM_REGS];
    logic [SEQ_W-1:0]     ytag_q [NUM_REGS];
    logic [SEQ_W-1:0]     ytag_d [NUM_REGS];
    logic                 ldw_q  [NUM_REGS];
    logic                 ldw_d  [NUM_REGS];
    logic [SEQ_W-1:0]     seq_q, seq_d;

    logic [REG_IDX_W-1:0] src_idx [NUM_SRC];
    logic                 ld_hazard;
    logic                 full_hazard;
    logic                 wr_req;
    logic                 ret_same;
    logic                 fire;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_idx[i] = issue_src[i*REG_IDX_W +: REG_IDX_W];
        end
    end

    always_comb begin
        src_pend  = '0;
        src_tag   = '0;
        ld_hazard = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_pend[i] = issue_src_en[i] && (src_idx[i] != '0) && (cnt_q[src_idx[i]] != '0);
            src_tag[i*SEQ_W +: SEQ_W] = ytag_q[src_idx[i]];
            // A load returning this very cycle is on the bypass bus, so it releases the stall.
            if (src_pend[i] && ldw_q[src_idx[i]] &&
                !(ld_ret_valid && (ld_ret_dst == src_idx[i]) && (ld_ret_tag == ytag_q[src_idx[i]]))) begin
                ld_hazard = 1'b1;
            end
        end
    end

    always_comb begin
        wr_req   = issue_wen && (issue_dst != '0);
        ret_same = retire_valid && (retire_dst == issue_dst);
`ifdef SCOREBOARD_WAW_STALL_EN
        full_hazard = wr_req && (cnt_q[issue_dst] != '0) &&
                      !(ret_same && (cnt_q[issue_dst] == CNT_W'(1)));
`else
        full_hazard = wr_req && (cnt_q[issue_dst] == CNT_MAX) && !ret_same;
`endif
        issue_ready = !ld_hazard && !full_hazard;
        fire        = issue_valid && issue_ready;
        issue_tag   = seq_q;
    end

    always_comb begin
        cnt_d  = cnt_q;
        ytag_d = ytag_q;
        ldw_d  = ldw_q;
        seq_d  = seq_q;
        if (ld_ret_valid && (ytag_q[ld_ret_dst] == ld_ret_tag)) begin
            ldw_d[ld_ret_dst] = 1'b0;
        end
        if (retire_valid && (cnt_q[retire_dst] != '0)) begin
            cnt_d[retire_dst] = cnt_q[retire_dst] - 1'b1;
        end
        if (fire) begin
            seq_d = seq_q + 1'b1;
        end
        // Issue overrides retire/return on the same register; a retire at cnt=0 stays ignored.
        if (fire && wr_req) begin
            cnt_d[issue_dst]  = (ret_same && (cnt_q[issue_dst] != '0)) ? cnt_q[issue_dst]
                                                                       : cnt_q[issue_dst] + 1'b1;
            ytag_d[issue_dst] = seq_q;
            ldw_d[issue_dst]  = issue_is_load;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r]  <= '0;
                ytag_q[r] <= '0;
                ldw_q[r]  <= 1'b0;
            end
            seq_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            ytag_q <= ytag_d;
            ldw_q  <= ldw_d;
            seq_q  <= seq_d;
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: expected outputs are queued per step and popped on sampling.
module tb_issue_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic        issue_wen;
    logic [4:0]  issue_dst;
    logic        issue_is_load;
    logic [9:0]  issue_src;
    logic [1:0]  issue_src_en;
    logic [3:0]  issue_tag;
    logic [1:0]  src_pend;
    logic [7:0]  src_tag;
    logic        ld_ret_valid;
    logic [4:0]  ld_ret_dst;
    logic [3:0]  ld_ret_tag;
    logic        retire_valid;
    logic [4:0]  retire_dst;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic [7:0]  exp;
    } exp_t;

    exp_t exp_q[$];

    issue_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_wen    (issue_wen),
        .issue_dst    (issue_dst),
        .issue_is_load(issue_is_load),
        .issue_src    (issue_src),
        .issue_src_en (issue_src_en),
        .issue_tag    (issue_tag),
        .src_pend     (src_pend),
        .src_tag      (src_tag),
        .ld_ret_valid (ld_ret_valid),
        .ld_ret_dst   (ld_ret_dst),
        .ld_ret_tag   (ld_ret_tag),
        .retire_valid (retire_valid),
        .retire_dst   (retire_dst)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        issue_valid = 0; issue_wen = 0; issue_dst = 0; issue_is_load = 0;
        issue_src = 0; issue_src_en = 0;
        ld_ret_valid = 0; ld_ret_dst = 0; ld_ret_tag = 0;
        retire_valid = 0; retire_dst = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_pop(input logic [7:0] obs);
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        assert (obs === e.exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", e.name, obs, e.exp);
        end
    endtask

    // Drive one cycle of stimulus from the falling edge, check combinational outputs, then clock.
    task automatic step(input string nm,
                        input logic v, input logic wen, input logic [4:0] dst, input logic ld,
                        input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] en,
                        input logic ldv, input logic [4:0] ldd, input logic [3:0] ldt,
                        input logic rv, input logic [4:0] rd,
                        input logic e_rdy, input logic [1:0] e_pend,
                        input logic [3:0] e_t0, input logic [3:0] e_t1, input logic [3:0] e_itag);
        issue_valid = v; issue_wen = wen; issue_dst = dst; issue_is_load = ld;
        issue_src = {s1, s0}; issue_src_en = en;
        ld_ret_valid = ldv; ld_ret_dst = ldd; ld_ret_tag = ldt;
        retire_valid = rv; retire_dst = rd;
        exp_q.push_back('{{nm, ".ready"}, {7'd0, e_rdy}});
        exp_q.push_back('{{nm, ".pend"},  {6'd0, e_pend}});
        exp_q.push_back('{{nm, ".tag0"},  {4'd0, e_t0}});
        exp_q.push_back('{{nm, ".tag1"},  {4'd0, e_t1}});
        exp_q.push_back('{{nm, ".itag"},  {4'd0, e_itag}});
        #1;
        check_pop({7'd0, issue_ready});
        check_pop({6'd0, src_pend});
        check_pop({4'd0, src_tag[3:0]});
        check_pop({4'd0, src_tag[7:4]});
        check_pop({4'd0, issue_tag});
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        do_reset();

        // reset state
        step("rst", 0,0,0,0, 0,0,2'b00, 0,0,0, 0,0, 1,2'b00,0,0,0);

        // load-use stall released by same-cycle load return
        step("t1_ld",    1,1,5,1, 0,0,2'b00, 0,0,0, 0,0, 1,2'b00,0,0,0);
        step("t1_stall", 1,1,6,0, 5,1,2'b11, 0,0,0, 0,0, 0,2'b01,0,0,1);
        step("t1_rel",   1,1,6,0, 5,1,2'b11, 1,5,0, 0,0, 1,2'b01,0,0,1);
        step("t1_after", 0,0,0,0, 5,6,2'b11, 0,0,0, 0,0, 1,2'b11,0,1,2);

        // plain RAW forwarding, then retire clears pending
        do_reset();
        step("t2_addi", 1,1,7,0, 0,0,2'b00, 0,0,0, 0,0, 1,2'b00,0,0,0);
        step("t2_sub",  1,1,8,0, 7,7,2'b11, 0,0,0, 0,0, 1,2'b11,0,0,1);
        step("t2_ret",  0,0,0,0, 0,0,2'b00, 0,0,0, 1,7, 1,2'b00,0,0,2);
        step("t2_rd",   1,0,0,0, 7,7,2'b11, 0,0,0, 0,0, 1,2'b00,0,0,2);

`ifndef SCOREBOARD_WAW_STALL_EN
        // stale load return from an older writer
        do_reset();
        step("t3_ld",    1,1,9,1,  0,0,2'b00, 0,0,0, 0,0, 1,2'b00,0,0,0);
        step("t3_addi",  1,1,9,0,  0,0,2'b00, 0,0,0, 0,0, 1,2'b00,0,0,1);
        step("t3_stale", 0,0,0,0,  0,0,2'b00, 1,9,0, 0,0, 1,2'b00,0,0,2);
        step("t3_rd",    1,0,0,0,  9,0,2'b01, 0,0,0, 0,0, 1,2'b01,1,0,2);
        step("t3_ldA",   1,1,11,1, 0,0,2'b00, 0,0,0, 0,0, 1,2'b00,0,0,3);
        step("t3_ldB",   1,1,11,1, 0,0,2'b00, 0,0,0, 0,0, 1,2'b00,0,0,4);
        step("t3_oldret",1,0,0,0,  11,0,2'b01, 1,11,3, 0,0, 0,2'b01,4,0,5);
        step("t3_newret",1,0,0,0,  11,0,2'b01, 1,11,4, 0,0, 1,2'b01,4,0,5);
        step("t3_tail",  0,0,0,0,  0,0,2'b00, 0,0,0, 0,0, 1,2'b00,0,0,6);
`endif

        // counter-full hazard
        do_reset();
`ifdef SCOREBOARD_WAW_STALL_EN
        step("t4_w1",    1,1,10,0, 0,0,2'b00, 0,0,0, 0,0,  1,2'b00,0,0,0);
        step("t4_w2",    1,1,10,0, 0,0,2'b00, 0,0,0, 0,0,  0,2'b00,0,0,1);
        step("t4_w2ret", 1,1,10,0, 0,0,2'b00, 0,0,0, 1,10, 1,2'b00,0,0,1);
        step("t4_w3",    1,1,10,0, 0,0,2'b00, 0,0,0, 0,0,  0,2'b00,0,0,2);
        step("t4_rd",    1,0,0,0,  10,0,2'b01, 0,0,0, 0,0, 1,2'b01,1,0,2);
`else
        step("t4_w1",    1,1,10,0, 0,0,2'b00, 0,0,0, 0,0,  1,2'b00,0,0,0);
        step("t4_w2",    1,1,10,0, 0,0,2'b00, 0,0,0, 0,0,  1,2'b00,0,0,1);
        step("t4_w3",    1,1,10,0, 0,0,2'b00, 0,0,0, 0,0,  1,2'b00,0,0,2);
        step("t4_w4",    1,1,10,0, 0,0,2'b00, 0,0,0, 0,0,  0,2'b00,0,0,3);
        step("t4_w4ret", 1,1,10,0, 0,0,2'b00, 0,0,0, 1,10, 1,2'b00,0,0,3);
        step("t4_w5",    1,1,10,0, 0,0,2'b00, 0,0,0, 0,0,  0,2'b00,0,0,4);
        step("t4_rd",    1,0,0,0,  10,0,2'b01, 0,0,0, 0,0, 1,2'b01,3,0,4);
`endif

        // x0 writes are untracked; tag wraps
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step("t5_x0", 1,1,0,0, 0,0,2'b11, 0,0,0, 0,0, 1,2'b00,0,0,4'(i));
        end
        step("t5_wrap", 0,0,0,0, 0,0,2'b11, 0,0,0, 0,0, 1,2'b00,0,0,0);
        step("t5_x3a",  1,1,3,0, 0,0,2'b00, 0,0,0, 0,0, 1,2'b00,0,0,0);
        step("t5_x3b",  1,1,3,0, 0,0,2'b00, 0,0,0, 0,0, 1,2'b00,0,0,1);
        step("t5_x3rd", 0,0,0,0, 3,0,2'b01, 0,0,0, 0,0, 1,2'b01,1,0,2);
        do_reset();
        step("t5_rst",  0,0,0,0, 3,0,2'b01, 0,0,0, 0,0, 1,2'b00,0,0,0);

        // retire underflow and same-cycle issue+retire
        do_reset();
        step("t6_ret0",   0,0,0,0, 0,0,2'b00, 0,0,0, 1,4, 1,2'b00,0,0,0);
        step("t6_rd0",    0,0,0,0, 4,0,2'b01, 0,0,0, 0,0, 1,2'b00,0,0,0);
        step("t6_w1",     1,1,4,0, 0,0,2'b00, 0,0,0, 0,0, 1,2'b00,0,0,0);
        step("t6_wret",   1,1,4,0, 0,0,2'b00, 0,0,0, 1,4, 1,2'b00,0,0,1);
        step("t6_rd1",    0,0,0,0, 4,0,2'b01, 0,0,0, 0,0, 1,2'b01,1,0,2);
        step("t6_ret1",   0,0,0,0, 0,0,2'b00, 0,0,0, 1,4, 1,2'b00,0,0,2);
        step("t6_rdz",    0,0,0,0, 4,0,2'b01, 0,0,0, 0,0, 1,2'b00,1,0,2);
        step("t6_wret0",  1,1,4,0, 0,0,2'b00, 0,0,0, 1,4, 1,2'b00,0,0,2);
        step("t6_rd2",    0,0,0,0, 4,0,2'b01, 0,0,0, 0,0, 1,2'b01,2,0,3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
